// File: rtl/vt_patch_extractor.sv
// vt_patch_extractor: buffers one PATCH_SIZE-row strip of a raster pixel stream and re-emits it as flattened ViT patch tokens
module vt_patch_extractor #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          IMG_WIDTH    = 64,
    parameter int          IMG_HEIGHT   = 64,
    parameter int          PATCH_SIZE   = 8,
    parameter int          NUM_CHANNELS = 3,
    parameter logic [31:0] WB_BASE      = 32'h3000_0000,
    localparam int         NUM_PATCHES  = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    localparam int         IW           = NUM_PATCHES > 1 ? $clog2(NUM_PATCHES) : 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    input  logic [DATA_WIDTH-1:0] i_image_data,
    input  logic                  i_image_valid,
    output logic                  o_image_ready,
    output logic [DATA_WIDTH-1:0] o_patch_data,
    output logic                  o_patch_valid,
    input  logic                  i_patch_ready,
    output logic                  o_patch_last,
    output logic                  o_frame_last,
    output logic [IW-1:0]         o_patch_idx,
    output logic                  o_irq
);
    localparam int PPR       = IMG_WIDTH / PATCH_SIZE;
    localparam int STRIPS    = IMG_HEIGHT / PATCH_SIZE;
    localparam int STRIP_LEN = PATCH_SIZE * IMG_WIDTH * NUM_CHANNELS;
    localparam int AW        = $clog2(STRIP_LEN);
    localparam int CW        = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int PW        = PATCH_SIZE > 1 ? $clog2(PATCH_SIZE) : 1;
    localparam int XW        = PPR > 1 ? $clog2(PPR) : 1;
    localparam int SW        = STRIPS > 1 ? $clog2(STRIPS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wptr_q, wptr_d, raddr;
    logic [CW-1:0]         ch_q, ch_d;
    logic [PW-1:0]         col_q, col_d, row_q, row_d;
    logic [XW-1:0]         px_q, px_d;
    logic [SW-1:0]         strip_q, strip_d;
    logic                  rdone_q, rdone_d, pv_q, pv_d, pl_q, pl_d, fl_q, fl_d, se_q, se_d;
    logic [DATA_WIDTH-1:0] pd_q, pd_d;
    logic [IW-1:0]         pidx_q, pidx_d;
    logic                  en_q, en_d, irq_en_q, irq_en_d, fd_q, fd_d, ovf_q, ovf_d;
    logic [31:0]           pcnt_q, pcnt_d, fcnt_q, fcnt_d, dat_q, dat_d, rdata;
    logic                  ack_q, ack_d, seen_q, seen_d, ready_q, ready_d, irq_q, irq_d;
    logic                  hit, wr, clr, kill, in_beat, xfer, load;
    logic                  ch_l, col_l, row_l, px_l, strip_l, tok_l;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] mem_q [STRIP_LEN];
    logic                  unused_ok;

    assign unused_ok     = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:3]};
    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign o_image_ready = ready_q;
    assign o_patch_data  = pd_q;
    assign o_patch_valid = pv_q;
    assign o_patch_last  = pl_q;
    assign o_frame_last  = fl_q;
    assign o_patch_idx   = pidx_q;
    assign o_irq         = irq_q;

    // next-state logic for the bus slave, the fill/drain FSM and the token read-ahead register
    always_comb begin
        hit      = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == WB_BASE[31:4]);
        ack_d    = hit && !seen_q;
        seen_d   = hit;
        off      = wbs_adr_i[3:2];
        wr       = ack_d && wbs_we_i && wbs_sel_i[0];
        en_d     = (wr && off == 2'd0) ? wbs_dat_i[0] : en_q;
        irq_en_d = (wr && off == 2'd0) ? wbs_dat_i[2] : irq_en_q;
        clr      = wr && off == 2'd0 && wbs_dat_i[1];
        kill     = clr || !en_d;
        in_beat  = i_image_valid && ready_q;
        xfer     = pv_q && i_patch_ready;
        load     = state_q == DRAIN && !rdone_q && (!pv_q || i_patch_ready);
        ch_l     = ch_q == CW'(NUM_CHANNELS - 1);
        col_l    = col_q == PW'(PATCH_SIZE - 1);
        row_l    = row_q == PW'(PATCH_SIZE - 1);
        px_l     = px_q == XW'(PPR - 1);
        strip_l  = strip_q == SW'(STRIPS - 1);
        tok_l    = ch_l && col_l && row_l;
        raddr    = AW'((int'(row_q) * IMG_WIDTH + int'(px_q) * PATCH_SIZE + int'(col_q)) * NUM_CHANNELS + int'(ch_q));
        state_d  = state_q;
        wptr_d   = wptr_q;
        ch_d     = ch_q;
        col_d    = col_q;
        row_d    = row_q;
        px_d     = px_q;
        strip_d  = strip_q;
        rdone_d  = rdone_q;
        pv_d     = pv_q;
        pd_d     = pd_q;
        pl_d     = pl_q;
        fl_d     = fl_q;
        se_d     = se_q;
        pidx_d   = pidx_q;
        pcnt_d   = pcnt_q;
        fcnt_d   = fcnt_q;
        fd_d     = fd_q && !(wr && off == 2'd1 && wbs_dat_i[1]);
        ovf_d    = (ovf_q && !(wr && off == 2'd1 && wbs_dat_i[2])) || (state_q != IDLE && i_image_valid && !ready_q);
        if (state_q == IDLE && en_q) state_d = FILL;
        if (state_q == FILL && in_beat) begin
            wptr_d = wptr_q == AW'(STRIP_LEN - 1) ? '0 : wptr_q + 1'b1;
            if (wptr_q == AW'(STRIP_LEN - 1)) state_d = DRAIN;
            if (wptr_q == '0 && strip_q == '0) pcnt_d = '0;
        end
        if (load) begin
            pv_d    = 1'b1;
            pd_d    = mem_q[raddr];
            pl_d    = tok_l;
            fl_d    = tok_l && px_l && strip_l;
            se_d    = tok_l && px_l;
            pidx_d  = IW'(int'(strip_q) * PPR + int'(px_q));
            ch_d    = ch_l ? '0 : ch_q + 1'b1;
            col_d   = ch_l ? (col_l ? '0 : col_q + 1'b1) : col_q;
            row_d   = (ch_l && col_l) ? (row_l ? '0 : row_q + 1'b1) : row_q;
            px_d    = tok_l ? (px_l ? '0 : px_q + 1'b1) : px_q;
            rdone_d = tok_l && px_l;
        end else if (xfer) pv_d = 1'b0;
        if (xfer && pl_q) pcnt_d = pcnt_q + 32'd1;
        if (xfer && fl_q) begin
            fd_d   = 1'b1;
            fcnt_d = fcnt_q + 32'd1;
        end
        if (xfer && se_q) begin
            state_d = FILL;
            rdone_d = 1'b0;
            strip_d = fl_q ? '0 : strip_q + 1'b1;
        end
        if (kill) begin
            state_d = IDLE;
            wptr_d  = '0;
            ch_d    = '0;
            col_d   = '0;
            row_d   = '0;
            px_d    = '0;
            strip_d = '0;
            rdone_d = 1'b0;
            pv_d    = 1'b0;
            pl_d    = 1'b0;
            fl_d    = 1'b0;
            se_d    = 1'b0;
            pidx_d  = '0;
            pcnt_d  = '0;
        end
        ready_d = state_d == FILL;
        irq_d   = fd_d && irq_en_d;
        rdata   = off == 2'd0 ? {29'd0, irq_en_q, 1'b0, en_q} :
                  off == 2'd1 ? {26'd0, state_q, 1'b0, ovf_q, fd_q, state_q != IDLE} :
                  off == 2'd2 ? pcnt_q : fcnt_q;
        dat_d   = (ack_d && !wbs_we_i) ? rdata : 32'd0;
    end

    // strip buffer; every location is rewritten before the drain reads it, so it needs no reset
    always_ff @(posedge wb_clk_i) begin
        if (state_q == FILL && in_beat) mem_q[wptr_q] <= i_image_data;
    end

    // all control state, counters and registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            ch_q     <= '0;
            col_q    <= '0;
            row_q    <= '0;
            px_q     <= '0;
            strip_q  <= '0;
            rdone_q  <= 1'b0;
            pv_q     <= 1'b0;
            pd_q     <= '0;
            pl_q     <= 1'b0;
            fl_q     <= 1'b0;
            se_q     <= 1'b0;
            pidx_q   <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            fd_q     <= 1'b0;
            ovf_q    <= 1'b0;
            pcnt_q   <= '0;
            fcnt_q   <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
            seen_q   <= 1'b0;
            ready_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            ch_q     <= ch_d;
            col_q    <= col_d;
            row_q    <= row_d;
            px_q     <= px_d;
            strip_q  <= strip_d;
            rdone_q  <= rdone_d;
            pv_q     <= pv_d;
            pd_q     <= pd_d;
            pl_q     <= pl_d;
            fl_q     <= fl_d;
            se_q     <= se_d;
            pidx_q   <= pidx_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            fd_q     <= fd_d;
            ovf_q    <= ovf_d;
            pcnt_q   <= pcnt_d;
            fcnt_q   <= fcnt_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            seen_q   <= seen_d;
            ready_q  <= ready_d;
            irq_q    <= irq_d;
        end
    end
endmodule

// File: tb/tb_vt_patch_extractor.sv
// tb_vt_patch_extractor: directed bench for an 8x8 image, 4x4 patches, 3 channels, sample = {y[2:0], x[2:0], ch[1:0]}
module tb_vt_patch_extractor;
    logic        wb_clk_i = 1'b0, wb_rst_i = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  i_image_data = 8'd0;
    logic        i_image_valid = 1'b0;
    logic        o_image_ready;
    logic [7:0]  o_patch_data;
    logic        o_patch_valid;
    logic        i_patch_ready = 1'b0;
    logic        o_patch_last, o_frame_last;
    logic [1:0]  o_patch_idx;
    logic        o_irq;
    logic        pv_at_ack = 1'b0;
    logic [31:0] v;
    int          checks = 0, errors = 0;

    vt_patch_extractor #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .PATCH_SIZE(4), .NUM_CHANNELS(3), .WB_BASE(32'h3000_0000)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .i_image_data(i_image_data), .i_image_valid(i_image_valid), .o_image_ready(o_image_ready),
        .o_patch_data(o_patch_data), .o_patch_valid(o_patch_valid), .i_patch_ready(i_patch_ready),
        .o_patch_last(o_patch_last), .o_frame_last(o_frame_last), .o_patch_idx(o_patch_idx), .o_irq(o_irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] insamp(input int s, input int i);
        int y, x, c;
        y = s * 4 + i / 24;
        x = (i / 3) % 8;
        c = i % 3;
        return 8'(y * 32 + x * 4 + c);
    endfunction

    function automatic logic [31:0] expo(input int s, input int k);
        int pp, e, y, x, c, last, fl;
        pp   = k / 48;
        e    = k % 48;
        c    = e % 3;
        x    = pp * 4 + (e / 3) % 4;
        y    = s * 4 + e / 12;
        last = (e == 47) ? 1 : 0;
        fl   = (s == 1 && pp == 1 && last == 1) ? 1 : 0;
        return 32'(((s * 2 + pp) << 10) | (fl << 9) | (last << 8) | (y * 32 + x * 4 + c));
    endfunction

    function automatic logic [31:0] obsp();
        return {20'd0, o_patch_idx, o_frame_last, o_patch_last, o_patch_data};
    endfunction

    task automatic feed(input int s, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            @(negedge wb_clk_i);
            while (!o_image_ready && t < 50) begin
                i_image_valid = 1'b0;
                @(negedge wb_clk_i);
                t++;
            end
            if (!o_image_ready) begin
                chk("feed_ready", 32'(o_image_ready), 32'd1);
                break;
            end
            i_image_valid = 1'b1;
            i_image_data  = insamp(s, i);
        end
        @(negedge wb_clk_i);
        i_image_valid = 1'b0;
    endtask

    task automatic drain(input int s, input int n, input bit stall);
        int k, t;
        bit held;
        logic [31:0] hv;
        k = 0;
        t = 0;
        held = 1'b0;
        hv = 32'd0;
        while (k < n) begin
            @(negedge wb_clk_i);
            if (held) chk("stall_hold", obsp() | {o_patch_valid, 31'd0}, hv | 32'h8000_0000);
            held = 1'b0;
            if (o_patch_valid) begin
                i_patch_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (i_patch_ready) begin
                    chk($sformatf("tok_s%0d_k%0d", s, k), obsp(), expo(s, k));
                    k++;
                end else begin
                    held = 1'b1;
                    hv = obsp();
                end
            end else i_patch_ready = 1'b0;
            t++;
            if (t > 1000) begin
                chk("drain_timeout", 32'(k), 32'(n));
                break;
            end
        end
        @(negedge wb_clk_i);
        i_patch_ready = 1'b0;
    endtask

    task automatic wb(input logic we, input logic [1:0] off, input logic [31:0] wd, output logic [31:0] rd);
        int t;
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = {28'h3000_000, off, 2'b00};
        wbs_dat_i = wd;
        wbs_sel_i = 4'hf;
        t = 0;
        @(negedge wb_clk_i);
        while (!wbs_ack_o && t < 8) begin
            @(negedge wb_clk_i);
            t++;
        end
        chk("ack_latency", 32'(t), 32'd0);
        rd = wbs_dat_o;
        pv_at_ack = o_patch_valid;
        @(negedge wb_clk_i);
        chk("ack_width", 32'(wbs_ack_o), 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wbw(input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] d;
        wb(1'b1, off, wd, d);
    endtask

    task automatic wbr(input logic [1:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        wb(1'b0, off, 32'd0, d);
        chk(tag, d, exp);
    endtask

    initial begin
        repeat (3) @(negedge wb_clk_i);
        chk("reset_outputs", {26'd0, o_irq, o_image_ready, o_patch_valid, wbs_ack_o, o_patch_last, o_frame_last}, 32'd0);
        wb_rst_i = 1'b1;
        wbr(2'd0, 32'h0, "rst_ctrl");
        wbr(2'd1, 32'h0, "rst_status");
        wbr(2'd2, 32'h0, "rst_pcnt");
        wbr(2'd3, 32'h0, "rst_fcnt");
        wbw(2'd0, 32'h5);
        wbr(2'd1, 32'h11, "status_fill");
        feed(0, 96);
        drain(0, 96, 1'b0);
        feed(1, 96);
        drain(1, 96, 1'b0);
        wbr(2'd2, 32'd4, "f1_pcnt");
        wbr(2'd3, 32'd1, "f1_fcnt");
        wbr(2'd1, 32'h13, "f1_status");
        chk("f1_irq", 32'(o_irq), 32'd1);
        wbw(2'd1, 32'h2);
        wbr(2'd1, 32'h11, "fd_w1c");
        chk("irq_cleared", 32'(o_irq), 32'd0);
        feed(0, 96);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            i_image_valid = 1'b1;
            i_image_data  = 8'hAA;
        end
        @(negedge wb_clk_i);
        i_image_valid = 1'b0;
        chk("ovf_hold", obsp() | {o_patch_valid, 31'd0}, 32'h8000_0000 | expo(0, 0));
        wbr(2'd1, 32'h25, "ovf_status");
        wbr(2'd2, 32'd0, "pcnt_cleared");
        wbr(2'd3, 32'd1, "fcnt_stream");
        wbw(2'd3, 32'h55);
        wbr(2'd3, 32'd1, "fcnt_ro");
        @(negedge wb_clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_adr_i = 32'h3000_0010;
        repeat (3) begin
            @(negedge wb_clk_i);
            chk("nodecode", {31'd0, wbs_ack_o} | wbs_dat_o, 32'd0);
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbw(2'd1, 32'h4);
        wbr(2'd1, 32'h21, "ovf_w1c");
        drain(0, 96, 1'b1);
        feed(1, 96);
        drain(1, 96, 1'b1);
        wbr(2'd3, 32'd2, "f2_fcnt");
        wbr(2'd2, 32'd4, "f2_pcnt");
        wbr(2'd1, 32'h13, "f2_status");
        chk("f2_irq", 32'(o_irq), 32'd1);
        wbw(2'd0, 32'h1);
        chk("irq_masked", 32'(o_irq), 32'd0);
        wbw(2'd0, 32'h5);
        chk("irq_unmasked", 32'(o_irq), 32'd1);
        feed(0, 96);
        drain(0, 10, 1'b0);
        wbw(2'd0, 32'h0);
        chk("abort_valid", 32'(pv_at_ack), 32'd0);
        chk("abort_ready", 32'(o_image_ready), 32'd0);
        wbr(2'd1, 32'h02, "abort_status");
        wbr(2'd2, 32'd0, "abort_pcnt");
        wbr(2'd3, 32'd2, "abort_fcnt");
        wbw(2'd0, 32'h5);
        feed(0, 96);
        drain(0, 96, 1'b0);
        feed(1, 96);
        drain(1, 96, 1'b0);
        wbr(2'd3, 32'd3, "f3_fcnt");
        wbr(2'd2, 32'd4, "f3_pcnt");
        feed(0, 40);
        wbw(2'd0, 32'h7);
        wbr(2'd0, 32'h5, "softclr_ctrl");
        wbr(2'd2, 32'd0, "softclr_pcnt");
        feed(0, 96);
        drain(0, 96, 1'b0);
        feed(1, 96);
        drain(1, 5, 1'b0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        chk("async_rst", {16'd0, o_irq, o_image_ready, o_patch_valid, wbs_ack_o, o_patch_idx, o_frame_last, o_patch_last, o_patch_data}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        wbr(2'd3, 32'd0, "post_rst_fcnt");
        wbr(2'd1, 32'd0, "post_rst_status");
        wbr(2'd0, 32'd0, "post_rst_ctrl");
        repeat (5) @(negedge wb_clk_i);
        chk("post_rst_valid", {30'd0, o_patch_valid, o_image_ready}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
